mips_multicycle_ctrl: RTL and testbench

//   Control unit for the multicycle MIPS datapath. Moore FSM that sequences fetch/decode/execute
//   and drives the datapath enables and mux selects. Contains the ALU decoder that produces

---
 rtl/mips_ctrl_pkg.sv | 47 ++++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 38 +++
 rtl/mips_multicycle_ctrl.sv | 129 ++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// MIPS_MUL_EN (optional) adds the mul funct to the ALU decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b100;
  localparam logic [2:0] ALUC_MUL = 3'b101;
  localparam logic [2:0] ALUC_SLT = 3'b110;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder: ALUOp + Funct -> ALUControl, flags functs the ALU cannot execute.
// MIPS_MUL_EN enables funct 011000 (mul).
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUC_W  = 3
) (
  input  aluop_t             ALUOp,
  input  logic [FUNCT_W-1:0] Funct,
  output logic [ALUC_W-1:0]  ALUControl,
  output logic               FunctIllegal
);

  always_comb begin
    ALUControl   = ALUC_ADD;
    FunctIllegal = 1'b0;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALUC_ADD;
      ALUOP_SUB: ALUControl = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (Funct)
          FN_ADD:  ALUControl = ALUC_ADD;
          FN_SUB:  ALUControl = ALUC_SUB;
          FN_AND:  ALUControl = ALUC_AND;
          FN_OR:   ALUControl = ALUC_OR;
          FN_SLT:  ALUControl = ALUC_SLT;
`ifdef MIPS_MUL_EN
          FN_MUL:  ALUControl = ALUC_MUL;
`endif
          default: FunctIllegal = 1'b1;
        endcase
      end
      default: ALUControl = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath; outputs decode straight from state.
// MIPS_MUL_EN (via alu_decoder) makes the mul funct a legal R-type.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int ALUC_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   Op,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic              Zero,
  output logic              IorD,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              RegDst,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        PCSrc,
  output logic              PCEn,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              IllegalOp
);

  state_t r_state, w_next;
  aluop_t w_aluop;
  logic   w_pcwrite, w_branch, w_funct_ill;

  alu_decoder #(.FUNCT_W(FUNCT_W), .ALUC_W(ALUC_W)) u_aludec (
    .ALUOp       (w_aluop),
    .Funct       (Funct),
    .ALUControl  (ALUControl),
    .FunctIllegal(w_funct_ill)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Reset skips the decode entirely, so every enable and select stays at its default.
  always_comb begin
    w_next    = S_FETCH;
    w_aluop   = ALUOP_ADD;
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    IllegalOp = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          IRWrite   = 1'b1;
          w_pcwrite = 1'b1;
          ALUSrcB   = 2'b01;
          w_next    = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (Op)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_R:         w_next = S_EXECUTE;
            OP_BEQ:       w_next = S_BRANCH;
            OP_ADDI:      w_next = S_ADDIEX;
            OP_J:         w_next = S_JUMP;
            default:      IllegalOp = 1'b1;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          w_next  = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          IorD   = 1'b1;
          w_next = S_MEMWB;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA   = 1'b1;
          w_aluop   = ALUOP_FUNCT;
          IllegalOp = w_funct_ill;
          w_next    = w_funct_ill ? S_FETCH : S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          w_aluop  = ALUOP_SUB;
          PCSrc    = 2'b01;
          w_branch = 1'b1;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          w_next  = S_ADDIWB;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCSrc     = 2'b10;
          w_pcwrite = 1'b1;
        end
        default: w_next = S_FETCH;
      endcase
    end
    PCEn = w_pcwrite | (w_branch & Zero);
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl: per-cycle vectors through a scoreboard queue,
// then instruction-latency sequences measured between consecutive fetches.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, BADOP = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_MUL = 6'b011000;

  logic       clk = 1'b0;
  logic       reset = 1'b1, Zero = 1'b0;
  logic [5:0] Op = 6'b0, Funct = 6'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, IllegalOp;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .PCEn(PCEn), .ALUControl(ALUControl), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  wire [15:0] w_obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                       ALUSrcB, PCSrc, PCEn, ALUControl, IllegalOp};

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic [15:0] exp;
    logic [15:0] msk;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] sb_exp[$];
  logic [15:0] sb_msk[$];
  int          sb_lat[$];
  int          n_vec = 0, n_bad = 0;

  // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,PCEn,ALUControl,IllegalOp}
  function automatic logic [15:0] mk(input logic iord, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, pcs, input logic pcen,
                                     input logic [2:0] aluc, input logic ill);
    return {iord, mw, irw, rd, m2r, rw, sa, sb, pcs, pcen, aluc, ill};
  endfunction

  task automatic add(input string nm, input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic [15:0] exp, input logic [15:0] msk = 16'hFFFF);
    vec_t v;
    v.name = nm; v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.exp = exp; v.msk = msk;
    tbl.push_back(v);
  endtask

  // Cycles from one IRWrite (FETCH) to the next, entered at the negedge of a FETCH cycle.
  task automatic lat(input string nm, input logic [5:0] op, input logic [5:0] fn, input int want);
    int cnt;
    bit seen;
    sb_lat.push_back(want);
    Op = op; Funct = fn; Zero = 1'b0; reset = 1'b0;
    cnt = 1; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (IRWrite) seen = 1;
      else cnt++;
    end
    n_vec++;
    begin
      int w;
      w = sb_lat.pop_front();
      if (!seen) begin
        n_bad++;
        $display("FAIL lat_%s: no refetch within 20 cycles, want %0d", nm, w);
      end else if (cnt != w) begin
        n_bad++;
        $display("FAIL lat_%s: got %0d cycles want %0d", nm, cnt, w);
      end
    end
  endtask

  logic [15:0] E_RST, E_F, E_D, E_DILL, E_MA, E_MR, E_MWB, E_MWR, E_AWB, E_AIW, E_J;
  logic [5:0]  r_fn[5];
  logic [2:0]  r_ac[5];

  initial begin
    E_RST  = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0);
    E_F    = mk(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010,0);
    E_D    = mk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,0);
    E_DILL = mk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,1);
    E_MA   = mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0);
    E_MR   = mk(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0);
    E_MWB  = mk(0,0,0,0,1,1,0,2'b00,2'b00,0,3'b010,0);
    E_MWR  = mk(1,1,0,0,0,0,0,2'b00,2'b00,0,3'b010,0);
    E_AWB  = mk(0,0,0,1,0,1,0,2'b00,2'b00,0,3'b010,0);
    E_AIW  = mk(0,0,0,0,0,1,0,2'b00,2'b00,0,3'b010,0);
    E_J    = mk(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b010,0);
    r_fn = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    r_ac = '{3'b010, 3'b100, 3'b000, 3'b001, 3'b110};

    add("rst_a", 1, LW, 0, 0, E_RST);
    add("rst_b", 1, LW, 0, 0, E_RST);
    add("lw_f", 0, LW, 0, 0, E_F);   add("lw_d", 0, LW, 0, 0, E_D);
    add("lw_ma", 0, LW, 0, 0, E_MA); add("lw_mr", 0, LW, 0, 0, E_MR);
    add("lw_wb", 0, LW, 0, 0, E_MWB);
    add("sw_f", 0, SW, 0, 0, E_F);   add("sw_d", 0, SW, 0, 0, E_D);
    add("sw_ma", 0, SW, 0, 0, E_MA); add("sw_mw", 0, SW, 0, 0, E_MWR);
    for (int i = 0; i < 5; i++) begin
      add("r_f", 0, RT, r_fn[i], 0, E_F);
      add("r_d", 0, RT, r_fn[i], 0, E_D);
      add("r_ex", 0, RT, r_fn[i], 0, mk(0,0,0,0,0,0,1,2'b00,2'b00,0,r_ac[i],0));
      add("r_wb", 0, RT, r_fn[i], 0, E_AWB);
    end
    add("beq1_f", 0, BEQ, 0, 0, E_F); add("beq1_d", 0, BEQ, 0, 1, E_D);
    add("beq1_br", 0, BEQ, 0, 1, mk(0,0,0,0,0,0,1,2'b00,2'b01,1,3'b100,0));
    add("beq0_f", 0, BEQ, 0, 1, E_F); add("beq0_d", 0, BEQ, 0, 1, E_D);
    add("beq0_br", 0, BEQ, 0, 0, mk(0,0,0,0,0,0,1,2'b00,2'b01,0,3'b100,0));
    add("addi_f", 0, ADDI, 0, 0, E_F);   add("addi_d", 0, ADDI, 0, 0, E_D);
    add("addi_ex", 0, ADDI, 0, 0, E_MA); add("addi_wb", 0, ADDI, 0, 0, E_AIW);
    add("j_f", 0, JMP, 0, 0, E_F); add("j_d", 0, JMP, 0, 0, E_D); add("j_j", 0, JMP, 0, 0, E_J);
    add("mul_f", 0, RT, F_MUL, 0, E_F); add("mul_d", 0, RT, F_MUL, 0, E_D);
`ifdef MIPS_MUL_EN
    add("mul_ex", 0, RT, F_MUL, 0, mk(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b101,0));
    add("mul_wb", 0, RT, F_MUL, 0, E_AWB);
`else
    add("mul_ex", 0, RT, F_MUL, 0, mk(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b000,1), 16'hFFF1);
`endif
    add("badfn_f", 0, RT, 6'b000000, 0, E_F); add("badfn_d", 0, RT, 6'b000000, 0, E_D);
    add("badfn_ex", 0, RT, 6'b000000, 0, mk(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b000,1), 16'hFFF1);
    add("badop_f", 0, BADOP, 0, 0, E_F); add("badop_d", 0, BADOP, 0, 0, E_DILL);
    add("rmr_f", 0, LW, 0, 0, E_F);  add("rmr_d", 0, LW, 0, 0, E_D);
    add("rmr_ma", 0, LW, 0, 0, E_MA); add("rmr_rst", 1, LW, 0, 0, E_RST);
    add("rmr_f2", 0, JMP, 0, 0, E_F); add("rmr_d2", 0, JMP, 0, 0, E_D);
    add("rmr_j", 0, JMP, 0, 0, E_J);
    add("rdc_f", 0, BADOP, 0, 0, E_F); add("rdc_rst", 1, BADOP, 0, 0, E_RST);
    add("rdc_f2", 0, RT, F_SUB, 0, E_F); add("rdc_d2", 0, RT, F_SUB, 0, E_D);
    add("rex_ex", 0, RT, F_SUB, 0, mk(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b100,0));
    add("rex_rst", 1, RT, F_SUB, 0, E_RST);
    add("rex_f", 0, JMP, 0, 0, E_F); add("rex_d", 0, JMP, 0, 0, E_D); add("rex_j", 0, JMP, 0, 0, E_J);

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      logic [15:0] e, m;
      reset = tbl[i].rst; Op = tbl[i].op; Funct = tbl[i].fn; Zero = tbl[i].z;
      sb_exp.push_back(tbl[i].exp); sb_msk.push_back(tbl[i].msk);
      @(negedge clk);
      e = sb_exp.pop_front(); m = sb_msk.pop_front();
      n_vec++;
      if (((w_obs ^ e) & m) != 16'h0) begin
        n_bad++;
        $display("FAIL %s [%0d]: got %h want %h (care %h)", tbl[i].name, i, w_obs, e, m);
      end
      @(posedge clk); #1;
    end

    // Table ends on a completed jump, so the FSM is fetching again here.
    reset = 1'b0; Op = LW;
    @(negedge clk);
    n_vec++;
    if (!IRWrite) begin
      n_bad++;
      $display("FAIL lat_align: IRWrite got %0b want 1", IRWrite);
    end
    lat("lw", LW, 0, 5);
    lat("sw", SW, 0, 4);
    lat("r_add", RT, F_ADD, 4);
    lat("addi", ADDI, 0, 4);
    lat("beq", BEQ, 0, 3);
    lat("j", JMP, 0, 3);
    lat("badop", BADOP, 0, 2);
`ifdef MIPS_MUL_EN
    lat("mul", RT, F_MUL, 4);
`else
    lat("mul", RT, F_MUL, 3);
`endif
    lat("badfn", RT, 6'b111111, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
